oser8_word_feeder: RTL

// - Upstream stage of an OSER8 serializer. Runs on the serializer fast clock (FCLK).
// - Derives PCLK = FCLK/4 and buffers incoming 8-bit words in a small FIFO.
// - Presents one word on D0..D7 per PCLK period, with a stable setup window around
//   the PCLK rising edge. Substitutes an idle pattern on underrun or when disabled.

---
 rtl/oser8_word_feeder.sv | 112 +++++++++++
 1 files changed

// File: rtl/oser8_word_feeder.sv
`default_nettype none
// ============================================================================
// oser8_word_feeder : FCLK/4 PCLK generator and word FIFO feeding OSER8 D0..D7
// Rev 1.0
// ============================================================================
module oser8_word_feeder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [7:0]  IDLE_WORD = 8'h55
) (
   input  logic                    clk_i,
   input  logic                    nrst_i,
   input  logic                    clr_i,
   input  logic                    enable_i,
   input  logic [7:0]              in_data_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic                    pclk_o,
   output logic [7:0]              d_o,
   output logic                    active_o,
   output logic                    load_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic [7:0]              underrun_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [1:0]  phase_q, phase_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  word_q, word_d;
   logic        active_q, active_d;
   logic        load_q, load_d;
   logic [7:0]  underrun_q, underrun_d;
   logic [7:0]  mem_q [DEPTH];

   logic [AW:0] level;
   logic        empty;
   logic        full;
   logic        load_ev;
   logic        push;
   logic        pop;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign empty   = (level == '0);
   assign full    = (level == FULL_LEVEL);
   // Load happens on the edge where phase wraps 3->0, i.e. the PCLK falling edge.
   assign load_ev = (phase_q == 2'd3);
   assign push    = in_valid_i && !full && !clr_i;
   assign pop     = load_ev && enable_i && !empty && !clr_i;

   always_comb begin
      phase_d    = phase_q + 2'd1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      word_d     = word_q;
      active_d   = active_q;
      load_d     = load_ev;
      underrun_d = underrun_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (load_ev) begin
         word_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : IDLE_WORD;
         active_d = pop;
         if (enable_i && empty && !clr_i && (underrun_q != 8'hFF))
            underrun_d = underrun_q + 8'd1;
      end

      // Flush leaves phase and the output word path alone so PCLK never glitches.
      if (clr_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         underrun_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         phase_q    <= 2'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         word_q     <= IDLE_WORD;
         active_q   <= 1'b0;
         load_q     <= 1'b0;
         underrun_q <= 8'd0;
      end else begin
         phase_q    <= phase_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         word_q     <= word_d;
         active_q   <= active_d;
         load_q     <= load_d;
         underrun_q <= underrun_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
   end

   assign in_ready_o = !full;
   assign pclk_o     = phase_q[1];
   assign d_o        = word_q;
   assign active_o   = active_q;
   assign load_o     = load_q;
   assign level_o    = level;
   assign underrun_o = underrun_q;

endmodule
`default_nettype wire
